// File: rtl/mem_port_arbiter_if.sv
// Bundle between requesters, the mem_port_arbiter and the shared memory.
// slave = arbiter side; master = requesters plus memory model side.
// Ports: req_* (per channel, packed k*WORD_SIZE), resp_*, mem_*, busy, num_access.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_CH    = 2
);
  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH-1:0]           req_write;
  logic [NUM_CH*WORD_SIZE-1:0] req_addr;
  logic [NUM_CH*WORD_SIZE-1:0] req_wdata;
  logic [NUM_CH-1:0]           req_ready;
  logic [NUM_CH-1:0]           resp_valid;
  logic [WORD_SIZE-1:0]        resp_rdata;
  logic                        mem_readM;
  logic                        mem_writeM;
  logic [WORD_SIZE-1:0]        mem_address;
  logic [WORD_SIZE-1:0]        mem_wdata;
  logic [WORD_SIZE-1:0]        mem_rdata;
  logic                        busy;
  logic [WORD_SIZE-1:0]        num_access;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_readM, mem_writeM, mem_address, mem_wdata,
    output busy, num_access
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_readM, mem_writeM, mem_address, mem_wdata,
    input  busy, num_access
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// NUM_CH requesters share one fixed-latency memory port, one access at a time.
// Ports: clk, reset (async, active-high), bus (mem_port_arbiter_if.slave).
// Round-robin by default; `define MEM_ARB_FIXED_PRIO_EN for fixed priority.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_CH      = 2,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CH_W-1:0]      r_owner;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_num;

  logic                 w_found;
  logic [CH_W-1:0]      w_win;
  logic                 w_grant;
  logic                 w_done;
  logic [WORD_SIZE-1:0] w_addr;
  logic [WORD_SIZE-1:0] w_wdata;
  logic                 w_write;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [CH_W-1:0]      r_rr_ptr;
`endif

  // Scan channels starting at the priority pointer; first hit wins.
  always_comb begin
    int k;
    w_found = 1'b0;
    w_win   = '0;
    k       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      k = i;
`else
      k = int'(r_rr_ptr) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
`endif
      if (!w_found && bus.req_valid[k]) begin
        w_found = 1'b1;
        w_win   = CH_W'(k);
      end
    end
  end

  assign w_addr  = bus.req_addr[int'(w_win)*WORD_SIZE +: WORD_SIZE];
  assign w_wdata = bus.req_wdata[int'(w_win)*WORD_SIZE +: WORD_SIZE];
  assign w_write = bus.req_write[w_win];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_done = 1'b1;
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= '0;
      r_cnt       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_num       <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      if (w_grant) begin
        r_owner     <= w_win;
        r_mem_read  <= ~w_write;
        r_mem_write <= w_write;
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
        r_cnt       <= CNT_W'(MEM_LATENCY - 1);
      end
      if (r_state == ACCESS && !w_done) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Commands drop on the same edge the read data is sampled.
      if (w_done) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_rdata     <= r_mem_write ? '0 : bus.mem_rdata;
      end
      if (r_state == RESP) begin
        r_num <= r_num + WORD_SIZE'(1);
`ifndef MEM_ARB_FIXED_PRIO_EN
        if (int'(r_owner) == NUM_CH - 1) r_rr_ptr <= '0;
        else r_rr_ptr <= r_owner + CH_W'(1);
`endif
      end
    end
  end

  assign bus.req_ready   = w_grant ? (ONE << w_win) : '0;
  assign bus.resp_valid  = (r_state == RESP) ? (ONE << r_owner) : '0;
  assign bus.resp_rdata  = r_rdata;
  assign bus.mem_readM   = r_mem_read;
  assign bus.mem_writeM  = r_mem_write;
  assign bus.mem_address = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.busy        = (r_state != IDLE);
  assign bus.num_access  = r_num;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
// Second instance (WORD_SIZE=4, MEM_LATENCY=1) exercises counter wrap.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.WORD_SIZE(16), .NUM_CH(2)) bus ();
  mem_port_arbiter_if #(.WORD_SIZE(4),  .NUM_CH(2)) bus2 ();

  mem_port_arbiter #(
    .WORD_SIZE(16), .NUM_CH(2), .MEM_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mem_port_arbiter #(
    .WORD_SIZE(4), .NUM_CH(2), .MEM_LATENCY(1)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_num  = 0;
  int   exp_ch;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  always_comb bus.mem_rdata = mem_fn(bus.mem_address);
  assign bus2.mem_rdata = 4'h0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (!reset && bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexp_resp", 32'(bus.resp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_ch", 32'(bus.resp_valid), 32'(1) << mon_e.ch);
        check("resp_data", 32'(bus.resp_rdata), 32'(mon_e.data));
      end
    end
    if (bus.busy)
      check("cmd_excl", 32'(bus.mem_readM & bus.mem_writeM), 32'd0);
  end

  initial begin
    reset = 1'b1;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus2.req_valid = '0;
    bus2.req_write = '0;
    bus2.req_addr  = '0;
    bus2.req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    @(negedge clk); #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp", 32'(bus.resp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_num", 32'(bus.num_access), 32'd0);
    check("rst_cmd", 32'({bus.mem_readM, bus.mem_writeM}), 32'd0);
    check("rst_addr", 32'(bus.mem_address), 32'd0);
    check("rst_rdata", 32'(bus.resp_rdata), 32'd0);

    // reset during the second ACCESS cycle aborts the access
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_addr  = {16'h0300, 16'h0000};
    #1 check("abort_grant", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk); #1;
    check("abort_pre", 32'(bus.mem_readM), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_rd", 32'(bus.mem_readM), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_addr", 32'(bus.mem_address), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_num", 32'(bus.num_access), 32'd0);

    // both channels requesting continuously
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr  = {16'h0200, 16'h0100};
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c % 4 == 0 && c < 16) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_ch = 0;
`else
        exp_ch = (c / 4) % 2;
`endif
        check("rr_grant", 32'(bus.req_ready), 32'(1) << exp_ch);
        sb.push_back('{exp_ch, mem_fn(exp_ch ? 16'h0200 : 16'h0100)});
        exp_num++;
      end
      if (c == 1) check("rr_busy_rdy", 32'(bus.req_ready), 32'd0);
      if (c == 13) bus.req_valid = '0;
      if (c == 16)
        check("rr_count", 32'(bus.num_access), 32'(exp_num));
    end

    // single read, channel 1
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_addr  = {16'h0040, 16'h0000};
    #1 check("rd_grant", 32'(bus.req_ready), 32'd2);
    sb.push_back('{1, 16'hBEEF});
    exp_num++;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("rd_cmd1", 32'({bus.mem_readM, bus.mem_writeM}), 32'd2);
    check("rd_addr", 32'(bus.mem_address), 32'h0040);
    @(negedge clk); #1;
    check("rd_cmd2", 32'(bus.mem_readM), 32'd1);
    @(negedge clk); #1;
    check("rd_cmd_off", 32'(bus.mem_readM), 32'd0);
    check("rd_resp", 32'(bus.resp_valid), 32'd2);
    check("rd_data", 32'(bus.resp_rdata), 32'hBEEF);
    @(negedge clk); #1;
    check("rd_num", 32'(bus.num_access), 32'(exp_num));
    check("rd_resp_off", 32'(bus.resp_valid), 32'd0);

    // single write, channel 0
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr  = {16'h0000, 16'h0010};
    bus.req_wdata = {16'h0000, 16'h1234};
    #1 check("wr_grant", 32'(bus.req_ready), 32'd1);
    sb.push_back('{0, 16'h0000});
    exp_num++;
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    #1;
    check("wr_cmd1", 32'({bus.mem_readM, bus.mem_writeM}), 32'd1);
    check("wr_addr", 32'(bus.mem_address), 32'h0010);
    check("wr_wdata", 32'(bus.mem_wdata), 32'h1234);
    @(negedge clk); #1;
    check("wr_cmd2", 32'({bus.mem_readM, bus.mem_writeM}), 32'd1);
    @(negedge clk); #1;
    check("wr_cmd_off", 32'(bus.mem_writeM), 32'd0);
    check("wr_resp", 32'(bus.resp_valid), 32'd1);
    check("wr_rdata", 32'(bus.resp_rdata), 32'd0);
    @(negedge clk); #1;
    check("wr_num", 32'(bus.num_access), 32'(exp_num));

    // counter wrap on the narrow instance
    @(negedge clk);
    bus2.req_valid = 2'b01;
    for (int i = 0; i < 100 && bus2.num_access != 4'hF; i++)
      @(negedge clk);
    check("wrap_pre", 32'(bus2.num_access), 32'hF);
    for (int i = 0; i < 10 && bus2.num_access == 4'hF; i++)
      @(negedge clk);
    check("wrap", 32'(bus2.num_access), 32'h0);
    bus2.req_valid = '0;

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised memory-port arbiter: NUM_CH requesters (instruction fetch, data load/store, later DMA/debug) share a single fixed-latency memory port.
- Generalises the current split i-side/d-side memory wiring to one unified port with per-channel request/response handshakes.
- Round-robin grant; one access in flight at a time.
- Sits between the CPU datapath and the unified memory model.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- NUM_CH, 2, number of requesting channels (>=2); channel index width CH_W = clog2(NUM_CH).
- MEM_LATENCY, 2, cycles the memory command is held before read data is valid (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_CH  per-channel request.
- req_write  input  NUM_CH  per-channel: 1 = write, 0 = read.
- req_addr  input  NUM_CH*WORD_SIZE  packed addresses; channel k in bits [k*WORD_SIZE +: WORD_SIZE].
- req_wdata  input  NUM_CH*WORD_SIZE  packed write data, same packing.
- req_ready  output  NUM_CH  one-hot accept strobe.
- resp_valid  output  NUM_CH  one-hot completion pulse.
- resp_rdata  output  WORD_SIZE  read data; qualified by resp_valid.
- mem_readM  output  1  memory read command.
- mem_writeM  output  1  memory write command.
- mem_address  output  WORD_SIZE  memory address.
- mem_wdata  output  WORD_SIZE  memory write data.
- mem_rdata  input  WORD_SIZE  memory read data.
- busy  output  1  high whenever state != IDLE.
- num_access  output  WORD_SIZE  count of completed accesses; wraps 2^WORD_SIZE-1 -> 0.

Behaviour:
- Reset values: state IDLE, rr_ptr 0, cnt 0, owner 0, all outputs 0.
- Reset is asynchronous and can occur in any state. A reset mid-access aborts the access: no resp_valid is issued and num_access is not incremented.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - If any req_valid is set, the winner is the first requesting channel scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - req_ready[winner]=1 combinationally in that same cycle; all other req_ready bits are 0.
  - On the clock edge: latch owner, write, addr, wdata; set cnt=MEM_LATENCY-1; go to ACCESS.
  - If no request is present, stay in IDLE.
- req_ready is 0 in every state other than IDLE. A requester holds req_valid and its fields stable until it sees req_ready.
- ACCESS:
  - Registered outputs: mem_readM=~write, mem_writeM=write, mem_address=latched addr, mem_wdata=latched wdata.
  - These are held for exactly MEM_LATENCY cycles.
  - cnt decrements each cycle.
  - When cnt==0: on a read, capture mem_rdata into rdata_q (for a write, rdata_q=0); deassert both commands on the edge; go to RESP.
- RESP:
  - resp_valid[owner]=1 for exactly one cycle; resp_rdata=rdata_q. The response pulse also serves as the write acknowledge.
  - num_access increments.
  - rr_ptr = (owner+1) mod NUM_CH; return to IDLE.
  - resp_rdata holds its value until the next RESP and reads 0 after reset.
- Latency and throughput:
  - Grant to response: MEM_LATENCY+1 cycles.
  - Back-to-back issue interval: MEM_LATENCY+2 cycles.
- Simultaneous requests: exactly one grant. Losing channels keep req_valid asserted and win on later arbitration rounds.
- Starvation bound: with NUM_CH channels all requesting continuously, each is served within NUM_CH rounds.
- Toggling req_valid after the grant has no effect on the in-flight access.
- mem_readM and mem_writeM are never high simultaneously.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index requesting channel always wins (channel 0 = instruction fetch highest); rr_ptr is neither implemented nor updated.
- Undefined (default): round-robin as described in Behaviour.
- All other timing is identical in both modes.

Test Plan:
- Single read, channel 1, addr 0x0040, memory returns 0xBEEF, MEM_LATENCY=2 -> req_ready[1] in cycle t; mem_readM high in t+1..t+2; resp_valid[1] with 0xBEEF in t+3; num_access=1.
- Write, channel 0, addr 0x0010, data 0x1234 -> mem_writeM high 2 cycles with address 0x0010 and data 0x1234; resp_valid[0] pulse with resp_rdata=0; mem_readM stays 0.
- Both channels requesting continuously, round-robin -> grant order 0,1,0,1; a new grant every 4 cycles; num_access=4 after 16 cycles.
- Same traffic with MEM_ARB_FIXED_PRIO_EN defined -> channel 0 granted every round; channel 1 never granted while channel 0 requests.
- Reset asserted in the second ACCESS cycle -> all outputs 0 immediately (asynchronous); no resp_valid; num_access unchanged at 0; a following request is granted to channel 0 first.
- num_access preloaded to 0xFFFF via a forced sequence, then one access -> num_access wraps to 0x0000.
